// File: rtl/lc3_ctrl_pkg.sv
// Shared types for the LC-3 control unit: FSM state encoding, opcodes, datapath mux
// encodings, the packed control word, and the opcode dispatch helper.
// Optional feature macro: LC3_INDIRECT_EN (LDI/STI support; otherwise they dispatch to ILL).
package lc3_ctrl_pkg;

  typedef enum logic [4:0] {
    StReset, StF1, StF2, StF3, StDecode, StAlu, StAddr, StRd, StInd, StWb,
    StStData, StWr, StBr, StJmp, StLea, StIll, StHalt
  } state_e;

  typedef enum logic [3:0] {
    OpBr  = 4'b0000, OpAdd = 4'b0001, OpLd  = 4'b0010, OpSt  = 4'b0011,
    OpAnd = 4'b0101, OpLdr = 4'b0110, OpStr = 4'b0111, OpNot = 4'b1001,
    OpLdi = 4'b1010, OpSti = 4'b1011, OpJmp = 4'b1100, OpLea = 4'b1110,
    OpTrap = 4'b1111
  } opcode_e;

  typedef enum logic [1:0] {PcmuxInc = 2'b00, PcmuxBus = 2'b01, PcmuxAdder = 2'b10} pcmux_e;
  typedef enum logic [1:0] {DrmuxIr = 2'b00, DrmuxR7 = 2'b01} drmux_e;
  typedef enum logic [1:0] {Sr1Ir86 = 2'b00, Sr1Ir119 = 2'b01} sr1mux_e;
  typedef enum logic [1:0] {
    Addr2Zero = 2'b00, Addr2Off6 = 2'b01, Addr2Off9 = 2'b10, Addr2Off11 = 2'b11
  } addr2mux_e;
  typedef enum logic [1:0] {AlukAdd = 2'b00, AlukAnd = 2'b01, AlukNot = 2'b10, AlukPass = 2'b11} aluk_e;

  typedef struct packed {
    logic       ld_mar, ld_mdr, ld_ir, ld_reg, ld_cc, ld_pc;
    logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux, drmux, sr1mux;
    logic       addr1mux;
    logic [1:0] addr2mux;
    logic       marmux;
    logic [1:0] aluk;
    logic       sr2mux, mem_en, r_w, illegal;
  } ctrl_t;

  function automatic logic is_indirect(input logic [3:0] op);
    return (op == OpLdi) || (op == OpSti);
  endfunction

  // Execute state entered from DECODE.
  function automatic state_e dispatch(input logic [3:0] op);
    case (op)
      OpAdd, OpAnd, OpNot:      return StAlu;
      OpLd, OpLdr, OpSt, OpStr: return StAddr;
`ifdef LC3_INDIRECT_EN
      OpLdi, OpSti:             return StAddr;
`endif
      OpBr:                     return StBr;
      OpJmp:                    return StJmp;
      OpLea:                    return StLea;
      OpTrap:                   return StHalt;
      default:                  return StIll;
    endcase
  endfunction

endpackage

// File: rtl/lc3_ctrl_outdec.sv
// Combinational control-word decoder: state (+ opcode, IR[5], ben) -> datapath controls.
// Ports: i_state current FSM state, i_opcode IR[15:12], i_ir5 IR[5], i_ben latched branch
// enable, o_ctrl packed control word.
// Optional feature macro: LC3_INDIRECT_EN (adds the IND state decode).
module lc3_ctrl_outdec
  import lc3_ctrl_pkg::*;
(
  input  state_e     i_state,
  input  logic [3:0] i_opcode,
  input  logic       i_ir5,
  input  logic       i_ben,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      StF1: begin
        o_ctrl.gate_pc = 1'b1;
        o_ctrl.ld_mar  = 1'b1;
        o_ctrl.ld_pc   = 1'b1;
        o_ctrl.pcmux   = PcmuxInc;
      end
      StF2, StRd: begin
        o_ctrl.mem_en = 1'b1;
        o_ctrl.ld_mdr = 1'b1;
      end
      StF3: begin
        o_ctrl.gate_mdr = 1'b1;
        o_ctrl.ld_ir    = 1'b1;
      end
      StAlu: begin
        o_ctrl.gate_alu = 1'b1;
        o_ctrl.ld_reg   = 1'b1;
        o_ctrl.ld_cc    = 1'b1;
        o_ctrl.drmux    = DrmuxIr;
        o_ctrl.sr1mux   = Sr1Ir86;
        o_ctrl.sr2mux   = i_ir5;
        if (i_opcode == OpAnd)      o_ctrl.aluk = AlukAnd;
        else if (i_opcode == OpNot) o_ctrl.aluk = AlukNot;
        else                        o_ctrl.aluk = AlukAdd;
      end
      StAddr: begin
        o_ctrl.gate_marmux = 1'b1;
        o_ctrl.ld_mar      = 1'b1;
        // Base+offset6 for LDR/STR, PC+offset9 for everything else.
        if (i_opcode == OpLdr || i_opcode == OpStr) begin
          o_ctrl.addr1mux = 1'b1;
          o_ctrl.addr2mux = Addr2Off6;
        end else begin
          o_ctrl.addr2mux = Addr2Off9;
        end
      end
`ifdef LC3_INDIRECT_EN
      StInd: begin
        o_ctrl.gate_mdr = 1'b1;
        o_ctrl.ld_mar   = 1'b1;
      end
`endif
      StWb: begin
        o_ctrl.gate_mdr = 1'b1;
        o_ctrl.ld_reg   = 1'b1;
        o_ctrl.ld_cc    = 1'b1;
        o_ctrl.drmux    = DrmuxIr;
      end
      StStData: begin
        o_ctrl.sr1mux   = Sr1Ir119;
        o_ctrl.aluk     = AlukPass;
        o_ctrl.gate_alu = 1'b1;
        o_ctrl.ld_mdr   = 1'b1;
      end
      StWr: begin
        o_ctrl.mem_en = 1'b1;
        o_ctrl.r_w    = 1'b1;
      end
      StBr: begin
        if (i_ben) begin
          o_ctrl.ld_pc    = 1'b1;
          o_ctrl.pcmux    = PcmuxAdder;
          o_ctrl.addr2mux = Addr2Off9;
        end
      end
      StJmp: begin
        o_ctrl.ld_pc    = 1'b1;
        o_ctrl.pcmux    = PcmuxAdder;
        o_ctrl.addr1mux = 1'b1;
        o_ctrl.addr2mux = Addr2Zero;
        o_ctrl.sr1mux   = Sr1Ir86;
      end
      StLea: begin
        o_ctrl.gate_marmux = 1'b1;
        o_ctrl.addr2mux    = Addr2Off9;
        o_ctrl.ld_reg      = 1'b1;
        o_ctrl.drmux       = DrmuxIr;
      end
      StIll:   o_ctrl.illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/lc3_control_fsm.sv
// LC-3 microsequenced control unit: fetch/decode/execute FSM driving the datapath controls.
// Ports: clk, rst (sync, active high); i_ir instruction, i_nzp condition codes, i_ready memory
// ready; o_ld_* register loads, o_gate_* bus drivers, o_*mux selects, o_aluk ALU op,
// o_mem_en/o_r_w memory strobe, o_halted/o_mem_fault sticky flags, o_illegal pulse.
// Optional feature macro: LC3_INDIRECT_EN (LDI/STI support).
module lc3_control_fsm
  import lc3_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] i_ir,
  input  logic [2:0]  i_nzp,
  input  logic        i_ready,
  output logic        o_ld_mar, o_ld_mdr, o_ld_ir, o_ld_reg, o_ld_cc, o_ld_pc,
  output logic        o_gate_pc, o_gate_mdr, o_gate_alu, o_gate_marmux,
  output logic [1:0]  o_pcmux,
  output logic [1:0]  o_drmux,
  output logic [1:0]  o_sr1mux,
  output logic        o_addr1mux,
  output logic [1:0]  o_addr2mux,
  output logic        o_marmux,
  output logic [1:0]  o_aluk,
  output logic        o_sr2mux,
  output logic        o_mem_en, o_r_w,
  output logic        o_halted,
  output logic        o_mem_fault,
  output logic        o_illegal
);

  localparam int unsigned CntW = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);
  // Count value seen on the MEM_WAIT_MAX-th consecutive non-ready cycle.
  localparam logic [CntW-1:0] WaitLast = CntW'(MEM_WAIT_MAX - 1);

  state_e          r_state;
  logic            r_ben;
  logic [CntW-1:0] r_wait_cnt;
  logic            r_halted;
  logic            r_mem_fault;
`ifdef LC3_INDIRECT_EN
  logic            r_ind_done;  // pointer already fetched; next RD is the data read
`endif

  logic [3:0] w_opcode;
  logic       w_unused_ir;
  ctrl_t      w_ctrl;

  assign w_opcode    = i_ir[15:12];
  assign w_unused_ir = ^{i_ir[8:6], i_ir[4:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StReset;
      r_ben       <= 1'b0;
      r_wait_cnt  <= '0;
      r_halted    <= 1'b0;
      r_mem_fault <= 1'b0;
`ifdef LC3_INDIRECT_EN
      r_ind_done  <= 1'b0;
`endif
    end else begin
      r_wait_cnt <= '0;  // only survives while still waiting, so every entry starts at 0
      case (r_state)
        StReset: r_state <= StF1;
        StF1:    r_state <= StF2;
        StF2, StRd, StWr: begin
          if (i_ready) begin
            if (r_state == StF2)      r_state <= StF3;
            else if (r_state == StWr) r_state <= StF1;
`ifdef LC3_INDIRECT_EN
            else if (is_indirect(w_opcode) && !r_ind_done) r_state <= StInd;
`endif
            else                      r_state <= StWb;
          end else if (r_wait_cnt == WaitLast) begin
            r_mem_fault <= 1'b1;
            r_halted    <= 1'b1;
            r_state     <= StHalt;
          end else begin
            r_wait_cnt <= r_wait_cnt + CntW'(1);
          end
        end
        StF3: r_state <= StDecode;
        StDecode: begin
          r_ben    <= |(i_ir[11:9] & i_nzp);
          r_halted <= (dispatch(w_opcode) == StHalt);
          r_state  <= dispatch(w_opcode);
`ifdef LC3_INDIRECT_EN
          r_ind_done <= 1'b0;
`endif
        end
        StAddr: begin
          if (w_opcode == OpSt || w_opcode == OpStr) r_state <= StStData;
          else                                       r_state <= StRd;
        end
`ifdef LC3_INDIRECT_EN
        StInd: begin
          r_ind_done <= 1'b1;
          r_state    <= (w_opcode == OpLdi) ? StRd : StStData;
        end
`endif
        StStData: r_state <= StWr;
        StAlu, StWb, StBr, StJmp, StLea, StIll: r_state <= StF1;
        StHalt:   r_state <= StHalt;
        default:  r_state <= StReset;
      endcase
    end
  end

  lc3_ctrl_outdec u_outdec (
    .i_state  (r_state),
    .i_opcode (w_opcode),
    .i_ir5    (i_ir[5]),
    .i_ben    (r_ben),
    .o_ctrl   (w_ctrl)
  );

  assign o_ld_mar      = w_ctrl.ld_mar;
  assign o_ld_mdr      = w_ctrl.ld_mdr;
  assign o_ld_ir       = w_ctrl.ld_ir;
  assign o_ld_reg      = w_ctrl.ld_reg;
  assign o_ld_cc       = w_ctrl.ld_cc;
  assign o_ld_pc       = w_ctrl.ld_pc;
  assign o_gate_pc     = w_ctrl.gate_pc;
  assign o_gate_mdr    = w_ctrl.gate_mdr;
  assign o_gate_alu    = w_ctrl.gate_alu;
  assign o_gate_marmux = w_ctrl.gate_marmux;
  assign o_pcmux       = w_ctrl.pcmux;
  assign o_drmux       = w_ctrl.drmux;
  assign o_sr1mux      = w_ctrl.sr1mux;
  assign o_addr1mux    = w_ctrl.addr1mux;
  assign o_addr2mux    = w_ctrl.addr2mux;
  assign o_marmux      = w_ctrl.marmux;
  assign o_aluk        = w_ctrl.aluk;
  assign o_sr2mux      = w_ctrl.sr2mux;
  assign o_mem_en      = w_ctrl.mem_en;
  assign o_r_w         = w_ctrl.r_w;
  assign o_illegal     = w_ctrl.illegal;
  assign o_halted      = r_halted;
  assign o_mem_fault   = r_mem_fault;

endmodule

// File: tb/tb_lc3_control_fsm.sv
// Directed bench for lc3_control_fsm: every cycle's output word is compared against
// hand-built constants. MEM_WAIT_MAX is set to 4 so the timeout path is short.
module tb_lc3_control_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] i_ir;
  logic [2:0]  i_nzp;
  logic        i_ready;
  logic        o_ld_mar, o_ld_mdr, o_ld_ir, o_ld_reg, o_ld_cc, o_ld_pc;
  logic        o_gate_pc, o_gate_mdr, o_gate_alu, o_gate_marmux;
  logic [1:0]  o_pcmux, o_drmux, o_sr1mux, o_addr2mux, o_aluk;
  logic        o_addr1mux, o_marmux, o_sr2mux, o_mem_en, o_r_w;
  logic        o_halted, o_mem_fault, o_illegal;

  always #5 clk = ~clk;

  lc3_control_fsm #(.MEM_WAIT_MAX(4)) u_dut (
    .clk (clk), .rst (rst), .i_ir (i_ir), .i_nzp (i_nzp), .i_ready (i_ready),
    .o_ld_mar (o_ld_mar), .o_ld_mdr (o_ld_mdr), .o_ld_ir (o_ld_ir), .o_ld_reg (o_ld_reg),
    .o_ld_cc (o_ld_cc), .o_ld_pc (o_ld_pc), .o_gate_pc (o_gate_pc), .o_gate_mdr (o_gate_mdr),
    .o_gate_alu (o_gate_alu), .o_gate_marmux (o_gate_marmux), .o_pcmux (o_pcmux),
    .o_drmux (o_drmux), .o_sr1mux (o_sr1mux), .o_addr1mux (o_addr1mux),
    .o_addr2mux (o_addr2mux), .o_marmux (o_marmux), .o_aluk (o_aluk), .o_sr2mux (o_sr2mux),
    .o_mem_en (o_mem_en), .o_r_w (o_r_w), .o_halted (o_halted), .o_mem_fault (o_mem_fault),
    .o_illegal (o_illegal)
  );

  logic [27:0] obs;
  assign obs = {o_ld_mar, o_ld_mdr, o_ld_ir, o_ld_reg, o_ld_cc, o_ld_pc,
                o_gate_pc, o_gate_mdr, o_gate_alu, o_gate_marmux,
                o_pcmux, o_drmux, o_sr1mux, o_addr1mux, o_addr2mux, o_marmux,
                o_aluk, o_sr2mux, o_mem_en, o_r_w, o_halted, o_mem_fault, o_illegal};

  localparam logic [27:0] LdMar = 28'd1 << 27, LdMdr = 28'd1 << 26, LdIr = 28'd1 << 25;
  localparam logic [27:0] LdReg = 28'd1 << 24, LdCc = 28'd1 << 23, LdPc = 28'd1 << 22;
  localparam logic [27:0] GatePc = 28'd1 << 21, GateMdr = 28'd1 << 20;
  localparam logic [27:0] GateAlu = 28'd1 << 19, GateMarmux = 28'd1 << 18;
  localparam logic [27:0] PcAdder = 28'd2 << 16, Sr1Ir119 = 28'd1 << 12;
  localparam logic [27:0] Addr1Sr1 = 28'd1 << 11, A2Off6 = 28'd1 << 9, A2Off9 = 28'd2 << 9;
  localparam logic [27:0] AlukAnd = 28'd1 << 6, AlukNot = 28'd2 << 6, AlukPass = 28'd3 << 6;
  localparam logic [27:0] Sr2 = 28'd1 << 5, MemEn = 28'd1 << 4, Rw = 28'd1 << 3;
  localparam logic [27:0] Halted = 28'd1 << 2, Fault = 28'd1 << 1, Illegal = 28'd1;

  localparam logic [27:0] WF1     = GatePc | LdMar | LdPc;
  localparam logic [27:0] WRead   = MemEn | LdMdr;
  localparam logic [27:0] WF3     = GateMdr | LdIr;
  localparam logic [27:0] WAdd    = GateAlu | LdReg | LdCc;
  localparam logic [27:0] WAddrPc = GateMarmux | LdMar | A2Off9;
  localparam logic [27:0] WAddrBr = GateMarmux | LdMar | Addr1Sr1 | A2Off6;
  localparam logic [27:0] WWb     = GateMdr | LdReg | LdCc;
  localparam logic [27:0] WStData = Sr1Ir119 | AlukPass | GateAlu | LdMdr;
  localparam logic [27:0] WWrite  = MemEn | Rw;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [27:0] got, input logic [27:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input string tag, input logic [27:0] exp);
    step();
    check_eq(tag, obs, exp);
  endtask

  // Wait state lasting w+1 cycles: ready is raised only in the final cycle.
  task automatic mem_access(input string tag, input logic [27:0] exp, input int w);
    for (int i = 0; i <= w; i++) begin
      step();
      check_eq(tag, obs, exp);
      i_ready = (i == w);
    end
  endtask

  task automatic fetch(input string tag, input int w);
    expect_word({tag, "_f1"}, WF1);
    mem_access({tag, "_f2"}, WRead, w);
    expect_word({tag, "_f3"}, WF3);
    expect_word({tag, "_dec"}, 28'd0);
  endtask

  initial begin
    int bad;
    rst = 1'b1; i_ir = 16'h0000; i_nzp = 3'b000; i_ready = 1'b1;
    step();
    step();
    check_eq("reset", obs, 28'd0);
    rst = 1'b0;

    i_ir = 16'h1042; fetch("add", 0);   expect_word("add_alu", WAdd);
    i_ir = 16'h5262; fetch("and", 0);   expect_word("and_alu", WAdd | AlukAnd | Sr2);
    i_ir = 16'h927F; fetch("not", 0);   expect_word("not_alu", WAdd | AlukNot | Sr2);

    i_ir = 16'h0C02; i_nzp = 3'b010;
    fetch("brt", 0); expect_word("br_taken", LdPc | PcAdder | A2Off9);
    i_nzp = 3'b001;
    fetch("brn", 0); expect_word("br_not", 28'd0);

    i_ir = 16'hC1C0; fetch("jmp", 0);   expect_word("jmp", LdPc | PcAdder | Addr1Sr1);
    i_ir = 16'hE205; fetch("lea", 0);   expect_word("lea", GateMarmux | A2Off9 | LdReg);

    // Three-cycle ready delay on both accesses, one short of the timeout.
    i_ir = 16'h2203; fetch("ld", 3);
    expect_word("ld_addr", WAddrPc);
    mem_access("ld_rd", WRead, 3);
    expect_word("ld_wb", WWb);

    i_ir = 16'h7242; fetch("str", 0);
    expect_word("str_addr", WAddrBr);
    expect_word("str_data", WStData);
    mem_access("str_wr", WWrite, 1);

    i_ir = 16'hA405; fetch("ldi", 0);
`ifdef LC3_INDIRECT_EN
    expect_word("ldi_addr", WAddrPc);
    mem_access("ldi_rd1", WRead, 1);
    expect_word("ldi_ind", GateMdr | LdMar);
    mem_access("ldi_rd2", WRead, 0);
    expect_word("ldi_wb", WWb);
`else
    expect_word("ldi_ill", Illegal);
`endif

    i_ir = 16'hD000; fetch("ill", 0);   expect_word("ill", Illegal);

    // Memory timeout: four non-ready cycles in F2, then HALT with the fault flag.
    i_ir = 16'h1042;
    expect_word("flt_f1", WF1);
    i_ready = 1'b0;
    for (int i = 0; i < 4; i++) expect_word("flt_wait", WRead);
    expect_word("flt_halt", Halted | Fault);
    expect_word("flt_sticky", Halted | Fault);
    rst = 1'b1;
    expect_word("flt_rst", 28'd0);
    rst = 1'b0; i_ready = 1'b1;

    // Reset in the middle of a write wait.
    i_ir = 16'h3203; fetch("st", 0);
    expect_word("st_addr", WAddrPc);
    expect_word("st_data", WStData);
    i_ready = 1'b0;
    expect_word("st_wr", WWrite);
    expect_word("st_wr_hold", WWrite);
    rst = 1'b1;
    expect_word("wr_rst", 28'd0);
    rst = 1'b0; i_ready = 1'b1;

    i_ir = 16'hF025; fetch("halt", 0);
    expect_word("halt", Halted);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      i_ready = 1'($urandom_range(0, 1));
      i_nzp   = 3'($urandom_range(0, 7));
      step();
      if (obs !== Halted) bad++;
    end
    check_eq("halt_hold", 28'(bad), 28'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
